// File: rtl/spinnaker_fpgas_spi_reg_access_if.sv
// Register-bank bus between the SPI bridge (master) and the control/diagnostic
// register bank (slave). READ_DATA_IN is a combinational function of ADDR_OUT.
interface spinnaker_fpgas_spi_reg_access_if #(
   parameter int REGA_BITS = 14,
   parameter int REGD_BITS = 32
);
   logic                 WRITE_OUT;
   logic [REGA_BITS-1:0] ADDR_OUT;
   logic [REGD_BITS-1:0] WRITE_DATA_OUT;
   logic [REGD_BITS-1:0] READ_DATA_IN;

   modport master (
      output WRITE_OUT,
      output ADDR_OUT,
      output WRITE_DATA_OUT,
      input  READ_DATA_IN
   );

   modport slave (
      input  WRITE_OUT,
      input  ADDR_OUT,
      input  WRITE_DATA_OUT,
      output READ_DATA_IN
   );
endinterface

// File: rtl/spinnaker_fpgas_spi_reg_access.sv
// SPI mode-0 target turning each frame (cmd, 16-bit addr, data) into a single
// register-bank read or write. SPI pins are oversampled in the CLK_IN domain.
module spinnaker_fpgas_spi_reg_access #(
   parameter int REGA_BITS = 14,
   parameter int REGD_BITS = 32
) (
   input  logic CLK_IN,
   input  logic RESET_IN,
   input  logic SPI_NSS_IN,
   input  logic SPI_SCLK_IN,
   input  logic SPI_MOSI_IN,
   output logic SPI_MISO_OUT,
   spinnaker_fpgas_spi_reg_access_if.master reg_bus
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_e;

   localparam int               CNT_W     = $clog2(((REGD_BITS > 16) ? REGD_BITS : 16) + 1);
   localparam logic [7:0]       CMD_WRITE = 8'h02;
   localparam logic [7:0]       CMD_READ  = 8'h03;
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(15);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REGD_BITS - 1);

   // Synchronizer taps: [0] metastable, [1] synchronized, [2] previous.
   logic [2:0] nss_sync_q, sclk_sync_q;
   logic [1:0] mosi_sync_q;
   logic       nss_fall_q, nss_rise_q, sclk_rise_q, sclk_fall_q;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [14:0]            shift_q, shift_d;
   logic                   is_read_q, is_read_d;
   logic [REGA_BITS-1:0]   addr_q, addr_d;
   logic [REGD_BITS-1:0]   wdata_q, wdata_d;
   logic [REGD_BITS-1:0]   rd_sr_q, rd_sr_d;
   logic                   miso_q, miso_d;
   logic                   write_q, write_d;

   logic       mosi_bit;
   logic [7:0] cmd_word;

   assign mosi_bit = mosi_sync_q[1];
   assign cmd_word = {shift_q[6:0], mosi_bit};

   // NOTE: the NSS chain resets to "selected" (0) so a frame already running
   // when reset is released shows no falling edge and is never joined.
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         nss_sync_q  <= '0;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         nss_fall_q  <= 1'b0;
         nss_rise_q  <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the old value
         // of the stage before it, which is what turns this into a shift chain.
         nss_sync_q  <= {nss_sync_q[1:0], SPI_NSS_IN};
         sclk_sync_q <= {sclk_sync_q[1:0], SPI_SCLK_IN};
         mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI_IN};
         nss_fall_q  <=  nss_sync_q[2] & ~nss_sync_q[1];
         nss_rise_q  <= ~nss_sync_q[2] &  nss_sync_q[1];
         sclk_rise_q <= ~sclk_sync_q[2] &  sclk_sync_q[1];
         sclk_fall_q <=  sclk_sync_q[2] & ~sclk_sync_q[1];
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (nss_fall_q) state_d = CMD;
         CMD:  if (sclk_rise_q && bit_cnt_q == CMD_LAST)
                  state_d = (cmd_word == CMD_WRITE || cmd_word == CMD_READ) ? ADDR : DONE;
         ADDR: if (sclk_rise_q && bit_cnt_q == ADDR_LAST) state_d = DATA;
         DATA: if (sclk_rise_q && bit_cnt_q == DATA_LAST) state_d = DONE;
         DONE: state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (nss_rise_q) state_d = IDLE;
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      is_read_d = is_read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_sr_d   = rd_sr_q;
      miso_d    = miso_q;
      write_d   = 1'b0;

      if (state_d != state_q)
         bit_cnt_d = '0;
      else if (sclk_rise_q && (state_q == CMD || state_q == ADDR || state_q == DATA))
         bit_cnt_d = bit_cnt_q + CNT_W'(1);

      if (!nss_rise_q) begin
         case (state_q)
            CMD: if (sclk_rise_q) begin
               shift_d = {shift_q[13:0], mosi_bit};
               if (bit_cnt_q == CMD_LAST) is_read_d = (cmd_word == CMD_READ);
            end
            ADDR: if (sclk_rise_q) begin
               shift_d = {shift_q[13:0], mosi_bit};
               if (bit_cnt_q == ADDR_LAST) addr_d = REGA_BITS'({shift_q, mosi_bit});
            end
            DATA: begin
               if (is_read_q) begin
                  // First falling edge of the data phase captures the register.
                  if (sclk_fall_q && bit_cnt_q == '0) begin
                     miso_d  = reg_bus.READ_DATA_IN[REGD_BITS-1];
                     rd_sr_d = reg_bus.READ_DATA_IN << 1;
                  end else if (sclk_fall_q) begin
                     miso_d  = rd_sr_q[REGD_BITS-1];
                     rd_sr_d = rd_sr_q << 1;
                  end
               end else if (sclk_rise_q) begin
                  wdata_d = {wdata_q[REGD_BITS-2:0], mosi_bit};
                  write_d = (bit_cnt_q == DATA_LAST);
               end
            end
            default: ;
         endcase
      end

      if (state_d != DATA) miso_d = 1'b0;
   end

   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         is_read_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_sr_q   <= '0;
         miso_q    <= 1'b0;
         write_q   <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         is_read_q <= is_read_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_sr_q   <= rd_sr_d;
         miso_q    <= miso_d;
         write_q   <= write_d;
      end
   end

   assign SPI_MISO_OUT           = miso_q;
   assign reg_bus.WRITE_OUT      = write_q;
   assign reg_bus.ADDR_OUT       = addr_q;
   assign reg_bus.WRITE_DATA_OUT = wdata_q;

endmodule

// File: tb/tb_spinnaker_fpgas_spi_reg_access.sv
// Directed plus randomized SPI frames against a register-bank model; expected
// bus activity and MISO streams come from a frame-level reference model.
module tb_spinnaker_fpgas_spi_reg_access;

   localparam int REGA_BITS = 14;
   localparam int REGD_BITS = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic nss = 1'b1;
   logic sclk = 1'b0;
   logic mosi = 1'b0;
   logic miso;

   spinnaker_fpgas_spi_reg_access_if #(.REGA_BITS(REGA_BITS), .REGD_BITS(REGD_BITS)) rbus ();

   spinnaker_fpgas_spi_reg_access #(.REGA_BITS(REGA_BITS), .REGD_BITS(REGD_BITS)) dut (
      .CLK_IN       (clk),
      .RESET_IN     (reset),
      .SPI_NSS_IN   (nss),
      .SPI_SCLK_IN  (sclk),
      .SPI_MOSI_IN  (mosi),
      .SPI_MISO_OUT (miso),
      .reg_bus      (rbus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register bank seen by the DUT.
   logic [31:0] bank [0:16383];
   assign rbus.READ_DATA_IN = bank[rbus.ADDR_OUT];

   int          wr_cnt = 0;
   logic [13:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   int          wr_cyc = 0;
   int          last_rise_cyc = 0;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [31:0] exp_mem [int];
   logic [13:0] exp_addr = '0;
   logic [31:0] exp_wdata = '0;

   function automatic logic [31:0] init_pat(input int a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [31:0] exp_read(input logic [13:0] a);
      if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
      return init_pat(int'(a));
   endfunction

   initial begin
      for (int i = 0; i < 16384; i++) bank[i] = init_pat(i);
      bank[5] = 32'h1234_5678;
      forever begin
         @(negedge clk);
         if (rbus.WRITE_OUT === 1'b1) begin
            wr_cnt++;
            wr_addr = rbus.ADDR_OUT;
            wr_data = rbus.WRITE_DATA_OUT;
            wr_cyc  = cyc;
            bank[rbus.ADDR_OUT] = rbus.WRITE_DATA_OUT;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drives one frame of nbits (<= 56) bits; reset_at >= 0 pulses RESET_IN
   // before that bit while NSS stays low. Returns MISO sampled at each rise.
   task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [31:0] data, input int nbits,
                            input int reset_at, output logic [55:0] mv);
      logic [55:0] bits;
      bits = {cmd, addr, data};
      mv   = '0;
      nss  = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == reset_at) begin
            reset = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (2) @(negedge clk);
            check("reset_write", 64'(rbus.WRITE_OUT), 64'(0));
            check("reset_addr", 64'(rbus.ADDR_OUT), 64'(0));
            check("reset_wdata", 64'(rbus.WRITE_DATA_OUT), 64'(0));
            check("reset_miso", 64'(miso), 64'(0));
         end
         mosi = bits[55-i];
         repeat (6) @(negedge clk);
         mv = {mv[54:0], miso};
         sclk = 1'b1;
         last_rise_cyc = cyc;
         repeat (6) @(negedge clk);
         sclk = 1'b0;
      end
      mosi = 1'b0;
      repeat (6) @(negedge clk);
      nss = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic do_frame(input string name, input logic [7:0] cmd, input logic [15:0] addr,
                           input logic [31:0] data, input int nbits, input int reset_at);
      logic [55:0] mv, exp_mv;
      logic [13:0] a;
      logic        exp_wr;
      int          wr0, k;
      a      = addr[13:0];
      wr0    = wr_cnt;
      exp_wr = 1'b0;
      exp_mv = '0;
      if (cmd == 8'h03 && reset_at < 0) exp_mv = {24'b0, exp_read(a)} >> (56 - nbits);

      spi_frame(cmd, addr, data, nbits, reset_at, mv);

      if (reset_at >= 0) begin
         exp_addr  = '0;
         exp_wdata = '0;
      end else begin
         if ((cmd == 8'h02 || cmd == 8'h03) && nbits >= 24) exp_addr = a;
         if (cmd == 8'h02 && nbits > 24) begin
            k = nbits - 24;
            exp_wdata = (k >= 32) ? data : ((exp_wdata << k) | (data >> (32 - k)));
         end
         if (cmd == 8'h02 && nbits == 56) begin
            exp_wr = 1'b1;
            exp_mem[int'(a)] = data;
         end
      end

      check({name, "_writes"}, 64'(wr_cnt - wr0), 64'(exp_wr));
      check({name, "_miso_stream"}, 64'(mv), 64'(exp_mv));
      check({name, "_addr"}, 64'(rbus.ADDR_OUT), 64'(exp_addr));
      check({name, "_wdata"}, 64'(rbus.WRITE_DATA_OUT), 64'(exp_wdata));
      check({name, "_miso_idle"}, 64'(miso), 64'(0));
      if (exp_wr) begin
         check({name, "_wr_addr"}, 64'(wr_addr), 64'(a));
         check({name, "_wr_data"}, 64'(wr_data), 64'(data));
         check({name, "_wr_latency"}, 64'(wr_cyc - last_rise_cyc), 64'(4));
      end
   endtask

   initial begin
      exp_mem[5] = 32'h1234_5678;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("por_write", 64'(rbus.WRITE_OUT), 64'(0));
      check("por_addr", 64'(rbus.ADDR_OUT), 64'(0));
      check("por_wdata", 64'(rbus.WRITE_DATA_OUT), 64'(0));
      check("por_miso", 64'(miso), 64'(0));

      do_frame("write", 8'h02, 16'h0002, 32'hDEAD_BEEF, 56, -1);
      do_frame("read", 8'h03, 16'h0005, 32'h0, 56, -1);
      do_frame("abort", 8'h02, 16'h0003, 32'hFFFF_0000, 40, -1);
      do_frame("after_abort", 8'h02, 16'h0003, 32'h0000_FFFF, 56, -1);
      do_frame("bad_cmd", 8'h55, 16'h1234, 32'h5555_AAAA, 56, -1);
      do_frame("reset", 8'h02, 16'h0007, 32'h0BAD_F00D, 56, 40);
      do_frame("post_reset", 8'h02, 16'h0001, 32'h7654_3210, 56, -1);
      do_frame("b2b_write", 8'h02, 16'hC004, 32'hCAFE_F00D, 56, -1);
      do_frame("b2b_read", 8'h03, 16'h0004, 32'h0, 56, -1);
      do_frame("read_back3", 8'h03, 16'h0003, 32'h0, 56, -1);

      for (int n = 0; n < 24; n++) begin
         int          r, nb;
         logic [7:0]  c;
         logic [15:0] ad;
         r  = int'($urandom_range(0, 9));
         c  = (r < 4) ? 8'h02 : (r < 8) ? 8'h03 : 8'($urandom);
         ad = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 3)) << 14);
         nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 55)) : 56;
         do_frame("rand", c, ad, $urandom, nb, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spinnaker_fpgas_spi_reg_access.md
# spinnaker_fpgas_spi_reg_access

SPI target that bridges the board-management controller's SPI bus onto the top-level register bank interface. It decodes each SPI frame into a single register read or write, drives address, write data and write strobe, and returns read data to the controller on MISO. It sits between the FPGA SPI pins and the control/diagnostic register bank, and is the only initiator on that bank.

## Interface
- REGA_BITS, 14, register address width; must be ≤ 16
- REGD_BITS, 32, register data width
- CLK_IN  input  1  system clock; all logic in this domain
- RESET_IN  input  1  synchronous, active-high reset
- SPI_NSS_IN  input  1  SPI chip select, active low, asynchronous
- SPI_SCLK_IN  input  1  SPI clock, asynchronous, mode 0 (idle low)
- SPI_MOSI_IN  input  1  SPI data in, asynchronous
- SPI_MISO_OUT  output  1  SPI data out
- WRITE_OUT  output  1  one-cycle register write strobe
- ADDR_OUT  output  REGA_BITS  register address for reads and writes
- WRITE_DATA_OUT  output  REGD_BITS  register write data
- READ_DATA_IN  input  REGD_BITS  register read data, combinational function of ADDR_OUT

## Operation
- NSS, SCLK, MOSI each pass through a 2-FF synchronizer; SCLK rising/falling and NSS falling/rising edges detected on synchronized values.
- Frame, MSB first: 8-bit command, 16-bit address, REGD_BITS data. Command 0x02 = write, 0x03 = read, any other = ignored.
- MOSI sampled on SCLK rising; MISO updated on SCLK falling.
- States: IDLE, CMD, ADDR, DATA, DONE. Bit counter counts rising edges within the current field.
- IDLE -> CMD only on synchronized NSS falling edge. Frames in progress at reset exit are not joined.
- CMD -> ADDR after 8 bits. Unknown command -> DONE.
- ADDR -> DATA after 16 bits; ADDR_OUT loads address bits [REGA_BITS-1:0] on the cycle after the 16th address bit is detected; upper bits discarded.
- Read: on the first SCLK falling edge in DATA, shift register loads READ_DATA_IN and MISO drives its MSB; each later falling edge shifts one bit. DATA -> DONE after REGD_BITS rising edges.
- Write: REGD_BITS bits shifted into WRITE_DATA_OUT; on the cycle after the last bit's rising edge is detected, WRITE_OUT pulses high for exactly one cycle, then DATA -> DONE.
- DONE: further SCLK edges ignored, MISO 0, until NSS rises.
- NSS rising edge in any state -> IDLE immediately. If NSS rises mid-frame, no write is issued.
- MISO is 0 in all states except the DATA phase of a read.
- ADDR_OUT and WRITE_DATA_OUT hold their last values between frames. WRITE_DATA_OUT changes only during write DATA phase.

## Timing
- Reset values: WRITE_OUT 0, ADDR_OUT 0, WRITE_DATA_OUT 0, SPI_MISO_OUT 0, state IDLE, counters 0.
- Edge-detect latency: 3 CLK cycles from pin edge to internal edge pulse.
- MISO update: ≤ 4 CLK cycles after SCLK falling pin edge.
- Requirement: SCLK high and low phases each ≥ 5 CLK periods. NSS setup to first SCLK rise ≥ 5 CLK periods. NSS hold after last SCLK fall ≥ 5 CLK periods.
- WRITE_OUT asserts 4 CLK cycles after the last data bit's SCLK rising pin edge. ADDR_OUT and WRITE_DATA_OUT are stable in that cycle.
- ADDR_OUT is valid ≥ 1 CLK cycle before READ_DATA_IN is captured.
- Only one WRITE_OUT pulse per frame. Minimum gap between frames is NSS high ≥ 5 CLK periods.

## Test plan
- Write frame 0x02, addr 0x0002, data 0xDEADBEEF -> exactly one WRITE_OUT pulse, with ADDR_OUT=0x0002 and WRITE_DATA_OUT=0xDEADBEEF; MISO 0 throughout.
- Read frame 0x03, addr 0x0005, bench model returns 0x12345678 for addr 5 -> MISO shifts 0x12345678 MSB first; WRITE_OUT never asserts.
- Write frame with NSS raised after 40 bits -> no WRITE_OUT; next full write to addr 0x0003 with data 0x0000FFFF succeeds.
- Command 0x55 followed by 48 bits -> no WRITE_OUT, ADDR_OUT unchanged, MISO 0.
- RESET_IN asserted mid-write with NSS still low -> all outputs return to reset values; remaining bits ignored; no write until a fresh NSS falling edge.
- Back-to-back frames: write 0xCAFEF00D to addr 0x0004, then read addr 0x0004 -> read returns 0xCAFEF00D; address 0xC004 truncates to ADDR_OUT=0x0004.
